// File: rtl/scie_pipelined_fir.sv
// SCIE custom-instruction unit: 5-tap unsigned FIR with coefficient load,
// sample push and result read opcodes. Accumulator recomputed every cycle.
module scie_pipelined_fir #(
    parameter int XLEN   = 32,
    parameter int NTAPS  = 5,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic [XLEN-1:0] io_rd
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);

    localparam logic [6:0] OP_LOADC = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;

    function automatic logic [XLEN-1:0] scale_out(input logic [ACC_W-1:0] a);
        return XLEN'(a >> SHIFT);
    endfunction

    logic [COEF_W-1:0] coeff [NTAPS];
    logic [DATA_W-1:0] x_p0  [NTAPS];
    logic [ACC_W-1:0]  acc_p1;
    logic [ACC_W-1:0]  sum;

    logic [6:0] opcode;
    logic [2:0] idx;
    logic       do_loadc;
    logic       do_push;
    logic       do_read;

    logic unused_bits;
    assign unused_bits = ^{io_insn[31:7], io_rs1[XLEN-1:DATA_W], io_rs2[XLEN-1:3]};

    assign opcode   = io_insn[6:0];
    assign idx      = io_rs2[2:0];
    assign do_loadc = io_valid && (opcode == OP_LOADC);
    assign do_push  = io_valid && (opcode == OP_PUSH);
    assign do_read  = io_valid && (opcode == OP_READ);

    // Stage 0: coefficient bank and sample delay line
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                coeff[i] <= '0;
                x_p0[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                if (do_loadc && (int'(idx) == i)) begin
                    coeff[i] <= io_rs1[COEF_W-1:0];
                end
            end
            if (do_push) begin
                x_p0[0] <= io_rs1[DATA_W-1:0];
                for (int i = 1; i < NTAPS; i++) begin
                    x_p0[i] <= x_p0[i-1];
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sum = sum + ACC_W'(PROD_W'(coeff[i]) * PROD_W'(x_p0[i]));
        end
    end

    // Stage 1: accumulated dot product, refreshed every cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_p1 <= '0;
        end else begin
            acc_p1 <= sum;
        end
    end

    // Output: READ captures the most recent accumulator, otherwise holds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_rd <= '0;
        end else if (do_read) begin
            io_rd <= scale_out(acc_p1);
        end
    end

endmodule

// File: tb/tb_scie_pipelined_fir.sv
// Directed bench for scie_pipelined_fir with a queue scoreboard of expected io_rd values.
module tb_scie_pipelined_fir;

    localparam logic [6:0] OP_LOADC = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;

    logic        clock;
    logic        reset;
    logic        io_valid;
    logic [31:0] io_insn;
    logic [31:0] io_rs1;
    logic [31:0] io_rs2;
    logic [31:0] io_rd;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    // reference model state
    logic [15:0] mc [5];
    logic [15:0] mx [5];

    scie_pipelined_fir dut (
        .clock    (clock),
        .reset    (reset),
        .io_valid (io_valid),
        .io_insn  (io_insn),
        .io_rs1   (io_rs1),
        .io_rs2   (io_rs2),
        .io_rd    (io_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model_result();
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < 5; i++) s = s + 64'(mc[i]) * 64'(mx[i]);
        return 32'(s >> 16);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            mc[i] = 16'd0;
            mx[i] = 16'd0;
        end
    endtask

    task automatic exec(input logic vld, input logic [24:0] hi, input logic [6:0] op,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clock);
        io_valid = vld;
        io_insn  = {hi, op};
        io_rs1   = rs1;
        io_rs2   = rs2;
        @(posedge clock);
        #1;
        io_valid = 1'b0;
        io_insn  = 32'd0;
        io_rs1   = 32'd0;
        io_rs2   = 32'd0;
    endtask

    task automatic check(input string tag);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, observed=%0d", tag, io_rd);
        end else begin
            e = exp_q.pop_front();
            assert (io_rd === e) else begin
                bad++;
                $error("FAIL %s: observed=%0d expected=%0d", tag, io_rd, e);
            end
        end
    endtask

    task automatic loadc(input logic [31:0] idx, input logic [15:0] val);
        exec(1'b1, 25'd0, OP_LOADC, {16'h5A5A, val}, idx);
        if (idx < 5) mc[idx[2:0]] = val;
    endtask

    task automatic push(input logic [15:0] val);
        exec(1'b1, 25'd0, OP_PUSH, {16'hA5A5, val}, 32'hFFFF_FFFF);
        for (int i = 4; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = val;
    endtask

    task automatic idle();
        exec(1'b0, 25'd0, 7'd0, 32'd0, 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        exec(1'b1, 25'd0, OP_READ, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check(tag);
    endtask

    logic [15:0] cinit [5];
    logic [15:0] samp  [4];
    logic [31:0] sres  [4];
    logic [31:0] prev;

    initial begin
        cinit = '{16'd42535, 16'd13962, 16'd26464, 16'd16516, 16'd4733};
        samp  = '{16'd14231, 16'd5033, 16'd14163, 16'd31192};
        sres  = '{32'd19380, 32'd25525, 32'd28010, 32'd32319};
        io_valid = 1'b0;
        io_insn  = 32'd0;
        io_rs1   = 32'd0;
        io_rs2   = 32'd0;
        reset    = 1'b0;
        model_clear();

        repeat (3) @(posedge clock);
        #1;
        exp_q.push_back(32'd0);
        check("reset_rd");
        @(negedge clock);
        reset = 1'b1;

        do_read("read_after_reset", 32'd0);

        for (int i = 0; i < 5; i++) loadc(i, cinit[i]);
        push(16'd47615);
        idle();
        do_read("first_sample", 32'd30903);

        for (int i = 0; i < 4; i++) begin
            push(samp[i]);
            idle();
            do_read($sformatf("sample_%0d", i), sres[i]);
        end

        loadc(32'd5, 16'hFFFF);
        loadc(32'd6, 16'h1234);
        loadc(32'd7, 16'hBEEF);
        do_read("loadc_out_of_range", 32'd32319);

        exp_q.push_back(32'd32319);
        exec(1'b0, 25'd0, OP_READ, 32'd0, 32'd0);
        check("read_valid_low");

        exp_q.push_back(32'd32319);
        exec(1'b1, 25'd0, 7'h7B, 32'h0000_1111, 32'd0);
        check("unknown_opcode");

        prev = model_result();
        push(16'd777);
        do_read("read_right_after_push", prev);
        do_read("read_after_settle", model_result());

        exec(1'b1, 25'h1FF_FFFF, OP_PUSH, 32'h0000_2222, 32'd0);
        for (int i = 4; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = 16'h2222;
        idle();
        do_read("push_high_insn_bits", model_result());

        @(negedge clock);
        reset = 1'b0;
        #2;
        exp_q.push_back(32'd0);
        check("async_reset_rd");
        model_clear();
        @(negedge clock);
        reset = 1'b1;

        push(16'd1000);
        idle();
        do_read("post_reset_zero_coeff", 32'd0);

        loadc(32'd0, 16'hFFFF);
        push(16'hFFFF);
        idle();
        do_read("max_product", 32'd65534);

        push(16'd3);
        push(16'd40000);
        push(16'd65535);
        idle();
        do_read("back_to_back_push", model_result());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
